// File: rtl/result_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : result_tx_pkg
// Purpose  : Shared types and constants for the scan-result UART framer.
//            The frame length depends on RESULT_TX_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
package result_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] C_HDR0_DEFAULT = 8'hA5;
    localparam logic [7:0] C_HDR1_DEFAULT = 8'h5A;

    localparam int C_IDX_W = 4;

    localparam logic [C_IDX_W-1:0] C_FRAME_LEN_CSUM  = 4'd14;
    localparam logic [C_IDX_W-1:0] C_FRAME_LEN_PLAIN = 4'd13;

endpackage
`default_nettype wire

// File: rtl/result_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : result_tx_framer_if
// Purpose  : Result capture and UART byte handshake bundle for the framer.
// Revision : 1.0 - initial release
// ============================================================================
interface result_tx_framer_if;

    logic        rx_dv;
    logic [7:0]  s_CT;
    logic [15:0] s_FSA;
    logic [15:0] s_LSA;
    logic [15:0] obs_alert;
    logic [15:0] max_dist_angle;
    logic [15:0] min_dist_angle;
    logic        tx_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    // Producer of results / consumer of frame bytes.
    modport master (
        output rx_dv, s_CT, s_FSA, s_LSA, obs_alert, max_dist_angle, min_dist_angle, tx_ready,
        input  tx_dv, tx_byte, busy, frame_done, drop_cnt
    );

    // The framer itself.
    modport slave (
        input  rx_dv, s_CT, s_FSA, s_LSA, obs_alert, max_dist_angle, min_dist_angle, tx_ready,
        output tx_dv, tx_byte, busy, frame_done, drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/result_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : result_tx_framer
// Purpose  : Snapshots a scan result and serialises it as a headed byte frame
//            to a UART transmitter. Optional checksum byte: RESULT_TX_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module result_tx_framer
    import result_tx_pkg::*;
#(
    parameter logic [7:0] HDR0 = C_HDR0_DEFAULT,
    parameter logic [7:0] HDR1 = C_HDR1_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    result_tx_framer_if.slave   bus
);

`ifdef RESULT_TX_CHECKSUM_EN
    localparam logic [C_IDX_W-1:0] C_FRAME_LEN = C_FRAME_LEN_CSUM;
`else
    localparam logic [C_IDX_W-1:0] C_FRAME_LEN = C_FRAME_LEN_PLAIN;
`endif
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_FRAME_LEN - 4'd1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_IDX_W-1:0]   r_idx;
    logic [C_IDX_W-1:0]   w_idx_nxt;
    logic                 w_capture;
    logic                 w_tx_dv;
    logic                 w_busy;
    logic                 w_frame_done;
    logic [7:0]           w_byte_sel;

    logic [7:0]           r_ct;
    logic [15:0]          r_fsa;
    logic [15:0]          r_lsa;
    logic [15:0]          r_obs;
    logic [15:0]          r_max;
    logic [15:0]          r_min;
    logic [7:0]           r_drop_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_capture    = 1'b0;
        w_tx_dv      = 1'b0;
        w_busy       = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rx_dv) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_tx_dv = 1'b1;
                w_busy  = 1'b1;
                if (bus.tx_ready) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                w_busy       = 1'b1;
                w_frame_done = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ct  <= '0;
            r_fsa <= '0;
            r_lsa <= '0;
            r_obs <= '0;
            r_max <= '0;
            r_min <= '0;
        end else if (w_capture) begin
            r_ct  <= bus.s_CT;
            r_fsa <= bus.s_FSA;
            r_lsa <= bus.s_LSA;
            r_obs <= bus.obs_alert;
            r_max <= bus.max_dist_angle;
            r_min <= bus.min_dist_angle;
        end
    end

    // Results arriving while a frame is in flight are discarded but counted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (bus.rx_dv && (r_state != ST_IDLE) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

`ifdef RESULT_TX_CHECKSUM_EN
    logic [7:0] w_csum;
    assign w_csum = r_ct ^ r_fsa[7:0] ^ r_fsa[15:8] ^ r_lsa[7:0] ^ r_lsa[15:8]
                  ^ r_obs[7:0] ^ r_obs[15:8] ^ r_max[7:0] ^ r_max[15:8]
                  ^ r_min[7:0] ^ r_min[15:8];
`endif

    always_comb begin
        w_byte_sel = 8'h00;
        case (r_idx)
            4'd0:    w_byte_sel = HDR0;
            4'd1:    w_byte_sel = HDR1;
            4'd2:    w_byte_sel = r_ct;
            4'd3:    w_byte_sel = r_fsa[7:0];
            4'd4:    w_byte_sel = r_fsa[15:8];
            4'd5:    w_byte_sel = r_lsa[7:0];
            4'd6:    w_byte_sel = r_lsa[15:8];
            4'd7:    w_byte_sel = r_obs[7:0];
            4'd8:    w_byte_sel = r_obs[15:8];
            4'd9:    w_byte_sel = r_max[7:0];
            4'd10:   w_byte_sel = r_max[15:8];
            4'd11:   w_byte_sel = r_min[7:0];
            4'd12:   w_byte_sel = r_min[15:8];
`ifdef RESULT_TX_CHECKSUM_EN
            4'd13:   w_byte_sel = w_csum;
`endif
            default: w_byte_sel = 8'h00;
        endcase
    end

    // Byte bus is forced to zero outside SEND so reset clears it immediately.
    assign bus.tx_byte    = (r_state == ST_SEND) ? w_byte_sel : 8'h00;
    assign bus.tx_dv      = w_tx_dv;
    assign bus.busy       = w_busy;
    assign bus.frame_done = w_frame_done;
    assign bus.drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_result_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_tx_framer
// Purpose  : Self-checking bench for result_tx_framer against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_tx_framer;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   exp_drop = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    result_tx_framer_if bus ();

    result_tx_framer #(.HDR0(8'hA5), .HDR1(8'h5A)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, little-endian fields, optional XOR checksum.
    task automatic build_frame(input logic [7:0] ct, input logic [15:0] fsa, lsa, obs, mx, mn);
        logic [7:0] x;
        exp_q = {8'hA5, 8'h5A, ct, fsa[7:0], fsa[15:8], lsa[7:0], lsa[15:8],
                 obs[7:0], obs[15:8], mx[7:0], mx[15:8], mn[7:0], mn[15:8]};
`ifdef RESULT_TX_CHECKSUM_EN
        x = 8'h00;
        for (int i = 2; i < 13; i++) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endtask

    task automatic randomize_inputs();
        bus.s_CT           = 8'($urandom);
        bus.s_FSA          = 16'($urandom);
        bus.s_LSA          = 16'($urandom);
        bus.obs_alert      = 16'($urandom);
        bus.max_dist_angle = 16'($urandom);
        bus.min_dist_angle = 16'($urandom);
    endtask

    task automatic bump_drop();
        if (exp_drop < 255) exp_drop++;
    endtask

    task automatic start_frame(input logic [7:0] ct, input logic [15:0] fsa, lsa, obs, mx, mn);
        bus.s_CT = ct; bus.s_FSA = fsa; bus.s_LSA = lsa;
        bus.obs_alert = obs; bus.max_dist_angle = mx; bus.min_dist_angle = mn;
        build_frame(ct, fsa, lsa, obs, mx, mn);
        bus.tx_ready = 1'($urandom);
        bus.rx_dv    = 1'b1;
        @(negedge clk);
        bus.rx_dv    = 1'b0;
    endtask

    task automatic start_random_frame();
        start_frame(8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom));
    endtask

    // mode 0: always ready, 1: random ready, 2: repeating 1,0,0,1 pattern.
    task automatic drain(input int mode, input int n_drops);
        int   idx   = 0;
        int   cyc   = 0;
        int   drops = n_drops;
        logic rdy;
        while (idx < exp_q.size() && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom);
                default: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            bus.tx_ready = rdy;
            randomize_inputs();
            if (drops > 0 && cyc % 2 == 1) begin
                bus.rx_dv = 1'b1;
                drops--;
                bump_drop();
            end else begin
                bus.rx_dv = 1'b0;
            end
            chk("send_tx_dv", 16'(bus.tx_dv), 16'd1);
            chk("send_byte", 16'(bus.tx_byte), 16'(exp_q[idx]));
            chk("send_busy", 16'(bus.busy), 16'd1);
            if (rdy) idx++;
            cyc++;
            @(negedge clk);
        end
        bus.rx_dv    = 1'b0;
        bus.tx_ready = 1'($urandom);
        chk("frame_complete", 16'(idx), 16'(exp_q.size()));
        if (mode == 0) chk("b2b_cycles", 16'(cyc), 16'(exp_q.size()));
        chk("done_frame_done", 16'(bus.frame_done), 16'd1);
        chk("done_tx_dv", 16'(bus.tx_dv), 16'd0);
        chk("done_busy", 16'(bus.busy), 16'd1);
        chk("done_tx_byte", 16'(bus.tx_byte), 16'h00);
        @(negedge clk);
        chk("idle_frame_done", 16'(bus.frame_done), 16'd0);
        chk("idle_busy", 16'(bus.busy), 16'd0);
        chk("idle_tx_dv", 16'(bus.tx_dv), 16'd0);
        chk("drop_cnt", 16'(bus.drop_cnt), 16'(exp_drop));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_dv"}, 16'(bus.tx_dv), 16'd0);
        chk({tag, "_tx_byte"}, 16'(bus.tx_byte), 16'h00);
        chk({tag, "_busy"}, 16'(bus.busy), 16'd0);
        chk({tag, "_frame_done"}, 16'(bus.frame_done), 16'd0);
        chk({tag, "_drop_cnt"}, 16'(bus.drop_cnt), 16'h00);
    endtask

    initial begin
        bus.rx_dv = 1'b0;
        bus.tx_ready = 1'b0;
        bus.s_CT = '0; bus.s_FSA = '0; bus.s_LSA = '0;
        bus.obs_alert = '0; bus.max_dist_angle = '0; bus.min_dist_angle = '0;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_tx_dv", 16'(bus.tx_dv), 16'd0);

        // Directed frame, continuous ready.
        start_frame(8'h08, 16'h1234, 16'h5678, 16'h00FF, 16'h2000, 16'h1000);
        drain(0, 0);

        // Stalling pattern on the UART side.
        start_random_frame();
        drain(2, 0);

        // Results arriving mid-frame are dropped.
        start_random_frame();
        drain(1, 3);
        chk("drop_cnt_three", 16'(bus.drop_cnt), 16'd3);

        // Saturation of the drop counter while the UART stalls.
        start_random_frame();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 260; i++) begin
            randomize_inputs();
            bus.rx_dv = 1'b1;
            bump_drop();
            chk("stall_byte", 16'(bus.tx_byte), 16'hA5);
            @(negedge clk);
        end
        bus.rx_dv = 1'b0;
        chk("drop_cnt_sat", 16'(bus.drop_cnt), 16'hFF);
        drain(0, 0);

        // Reset in the middle of a frame.
        start_random_frame();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("pre_reset_byte", 16'(bus.tx_byte), 16'(exp_q[i]));
            @(negedge clk);
        end
        chk("pre_reset_tx_dv", 16'(bus.tx_dv), 16'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("midframe_reset");
        exp_drop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.tx_ready = 1'($urandom);
            chk("abandon_tx_dv", 16'(bus.tx_dv), 16'd0);
            chk("abandon_busy", 16'(bus.busy), 16'd0);
            @(negedge clk);
        end
        start_random_frame();
        drain(1, 0);

        // Assorted random frames.
        for (int f = 0; f < 4; f++) begin
            start_random_frame();
            drain(f % 3, f % 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_tx_framer.md
RESULT_TX_FRAMER -- requirements
Module: result_tx_framer

Interface
REQ-001 Parameter HDR0, default 8'hA5, first frame header byte.
REQ-002 Parameter HDR1, default 8'h5A, second frame header byte.
REQ-003 The port `clk` SHALL be: input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-004 The port `reset_n` SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 The port `rx_dv` SHALL be: input, 1 bit, one-cycle pulse marking a complete scan result on the result inputs.
REQ-006 The port `s_CT` SHALL be: input, 8 bits, sample count of the scan.
REQ-007 The ports `s_FSA` and `s_LSA` SHALL be: input, 16 bits each, first and last sample angle.
REQ-008 The port `obs_alert` SHALL be: input, 16 bits, obstacle bitmap.
REQ-009 The ports `max_dist_angle` and `min_dist_angle` SHALL be: input, 16 bits each, extreme-distance angles.
REQ-010 The port `tx_ready` SHALL be: input, 1 bit, UART transmitter can accept a byte this cycle.
REQ-011 The port `tx_dv` SHALL be: output, 1 bit, `tx_byte` is valid.
REQ-012 The port `tx_byte` SHALL be: output, 8 bits, frame byte offered to the UART transmitter.
REQ-013 The port `busy` SHALL be: output, 1 bit, high while a frame is pending or in transmission.
REQ-014 The port `frame_done` SHALL be: output, 1 bit, one-cycle pulse after the last byte is accepted.
REQ-015 The port `drop_cnt` SHALL be: output, 8 bits, count of results discarded because the block was busy.

Function
REQ-016 States SHALL be IDLE, SEND and DONE.
REQ-017 IDLE with `rx_dv`=1: snapshot all result inputs, clear byte index to 0, go to SEND next cycle.
REQ-018 Byte transfer SHALL occur only on a cycle with `tx_dv`=1 and `tx_ready`=1.
REQ-019 In SEND, `tx_dv` SHALL be 1, and `tx_byte` SHALL hold stable until the transfer occurs.
REQ-020 Frame byte order (indices 0..12): HDR0, HDR1, CT, FSA lo, FSA hi, LSA lo, LSA hi, obs lo, obs hi, max lo, max hi, min lo, min hi.
REQ-021 On each transfer, the index SHALL increment; a transfer of the last byte SHALL move to DONE.
REQ-022 DONE SHALL last exactly one cycle, assert `frame_done`=1, and return to IDLE.
REQ-023 Latency: `rx_dv` high in cycle N SHALL give `tx_dv`=1 with HDR0 in cycle N+1.
REQ-024 The back-to-back transfer rate SHALL be one byte per cycle when `tx_ready` is held 1.
REQ-025 `rx_dv` in SEND or DONE SHALL NOT alter the snapshot or the frame in progress.
  - Such an `rx_dv` SHALL increment `drop_cnt`, saturating at 8'hFF.
REQ-026 `busy` SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-027 `tx_dv` SHALL be 0 in IDLE and DONE.
REQ-028 `tx_ready` SHALL be ignored in IDLE and DONE.
REQ-029 Input changes after the snapshot SHALL NOT affect emitted bytes.

Reset
REQ-030 `reset_n`=0 SHALL immediately force the following, regardless of `clk`:
  - state IDLE, index 0, snapshot 0;
  - `tx_dv`=0, `tx_byte`=8'h00, `busy`=0, `frame_done`=0, `drop_cnt`=0.
REQ-031 A reset mid-frame SHALL abandon the frame; no remaining bytes SHALL be sent after release.
REQ-032 The first `rx_dv` after release SHALL start a fresh frame at HDR0.

Configuration
REQ-033 With macro RESULT_TX_CHECKSUM_EN defined:
  - the frame SHALL have 14 bytes;
  - index 13 SHALL be the XOR of bytes at indices 2..12.
REQ-034 Without RESULT_TX_CHECKSUM_EN, the frame SHALL end at index 12, and no checksum logic SHALL exist.

Structure
REQ-035 Shared package `result_tx_pkg` SHALL hold:
  - the state encoding;
  - default header constants;
  - frame-length constants for the checksum-on and checksum-off builds;
  - the byte-index width.
REQ-036 The block SHALL be a single module with no sub-module.
  - The byte select SHALL be an internal index-driven multiplexer over the snapshot.

Verification
REQ-037 Reset release, `rx_dv` pulse, `tx_ready`=1: bytes A5 5A 08 34 12 78 56 FF 00 00 20 00 10 on consecutive cycles; `frame_done` one cycle after the last byte. Inputs: CT=08, FSA=1234, LSA=5678, obs=00FF, max=2000, min=1000.
REQ-038 Same inputs with RESULT_TX_CHECKSUM_EN defined: 14th byte = CF; `frame_done` follows it.
REQ-039 `tx_ready` toggled 1,0,0,1 during SEND: `tx_byte` holds during low cycles; no byte is duplicated or skipped.
REQ-040 Three `rx_dv` pulses mid-frame with inputs changed: frame content unchanged; `drop_cnt`=3. Then 260 further busy pulses: `drop_cnt`=FF.
REQ-041 `reset_n` asserted after byte 5: `tx_dv`=0 at once; after release `tx_dv` stays 0 until a new `rx_dv`, which restarts the frame at A5.
